// File: rtl/conv2d_window_ctrl.sv
// conv2d_window_ctrl
// Sequences a raster-order pixel stream into a KxK sliding-window convolution:
// drives line-buffer writes, issues one window per window-producing pixel, and
// limits windows in flight with a credit counter sized to the output buffer.
// Optional statistics outputs (stall_cycles, frame_count) are compiled in when
// CONV2D_WINDOW_CTRL_STATS_EN is defined.
module conv2d_window_ctrl #(
    parameter int IMG_W   = 32,
    parameter int IMG_H   = 32,
    parameter int K       = 3,
    parameter int CREDITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     lb_push,
    output logic [$clog2(IMG_W)-1:0] lb_col,
    output logic [$clog2(IMG_H)-1:0] lb_row,
    output logic                     win_valid,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    input  logic                     out_fire,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     err
`ifdef CONV2D_WINDOW_CTRL_STATS_EN
    ,
    output logic [31:0]              stall_cycles,
    output logic [31:0]              frame_count
`endif
);

    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int CRW = $clog2(CREDITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [CRW-1:0]  r_credits;
    logic            r_err;
    logic            r_win_valid;
    logic [RW-1:0]   r_win_row;
    logic [CW-1:0]   r_win_col;

    logic            w_last_col;
    logic            w_last_row;
    logic            w_win_prod;
    logic            w_accept;
    logic            w_dec;
    logic            w_credits_empty;
    logic            w_credits_full;
    logic            w_stall_cond;

    assign w_last_col      = (r_col == CW'(IMG_W - 1));
    assign w_last_row      = (r_row == RW'(IMG_H - 1));
    assign w_win_prod      = (r_row >= RW'(K - 1)) && (r_col >= CW'(K - 1));
    assign w_credits_empty = (r_credits == '0);
    assign w_credits_full  = (r_credits == CRW'(CREDITS));
    // A window-producing pixel stalls until the output buffer has a free slot.
    assign w_stall_cond    = w_win_prod && w_credits_empty;
    assign w_accept        = in_valid && in_ready;
    assign w_dec           = w_accept && w_win_prod;

    assign lb_push   = w_accept;
    assign lb_col    = r_col;
    assign lb_row    = r_row;
    assign win_valid = r_win_valid;
    assign win_row   = r_win_row;
    assign win_col   = r_win_col;
    assign busy      = (r_state != S_IDLE);
    assign err       = r_err;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the combinational handshake and end-of-frame pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        frame_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_FILL;
            end
            S_FILL: begin
                in_ready = !w_stall_cond;
                if (w_accept && w_last_col && (r_row == RW'(K - 2))) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                in_ready = !w_stall_cond;
                if (w_accept && w_last_col && w_last_row) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_credits_full) begin
                    frame_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Raster position of the next pixel to accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Output-buffer credits; a return with the counter already full saturates and flags err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_credits <= CRW'(CREDITS);
            r_err     <= 1'b0;
        end else if (out_fire && !w_dec) begin
            if (w_credits_full) r_err     <= 1'b1;
            else                r_credits <= r_credits + CRW'(1);
        end else if (!out_fire && w_dec) begin
            r_credits <= r_credits - CRW'(1);
        end
    end

    // Window issue, one cycle after its bottom-right pixel is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else begin
            r_win_valid <= w_dec;
            if (w_dec) begin
                r_win_row <= r_row - RW'(K - 1);
                r_win_col <= r_col - CW'(K - 1);
            end
        end
    end

`ifdef CONV2D_WINDOW_CTRL_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_frame_count;

    // Free-running wrap-around counters of upstream stall cycles and completed frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_frame_count  <= '0;
        end else begin
            if (in_valid && !in_ready && ((r_state == S_FILL) || (r_state == S_RUN)))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (frame_done)
                r_frame_count <= r_frame_count + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign frame_count  = r_frame_count;
`endif

endmodule

// File: tb/tb_conv2d_window_ctrl.sv
// tb_conv2d_window_ctrl
// Directed frames against a pixel-index/credit model of the controller, checked
// every cycle, plus hand-computed expectations for window origins and stalls.
module tb_conv2d_window_ctrl;

    localparam int IMG_W   = 4;
    localparam int IMG_H   = 4;
    localparam int K       = 3;
    localparam int CREDITS = 2;

    logic clk = 1'b0;
    logic rst_n, start, in_valid, out_fire;
    logic in_ready, lb_push, win_valid, busy, frame_done, err;
    logic [$clog2(IMG_W)-1:0] lb_col, win_col;
    logic [$clog2(IMG_H)-1:0] lb_row, win_row;
`ifdef CONV2D_WINDOW_CTRL_STATS_EN
    logic [31:0] stall_cycles, frame_count;
`endif

    always #5 clk = ~clk;

    conv2d_window_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .CREDITS(CREDITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .lb_push(lb_push), .lb_col(lb_col), .lb_row(lb_row),
        .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
        .out_fire(out_fire), .busy(busy), .frame_done(frame_done), .err(err)
`ifdef CONV2D_WINDOW_CTRL_STATS_EN
        , .stall_cycles(stall_cycles), .frame_count(frame_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1 accepting pixels, 2 draining; pixel index = row*IMG_W+col.
    int m_phase = 0, m_n = 0, m_cred = CREDITS, m_wr = 0, m_wc = 0;
    bit m_err = 1'b0, m_wv = 1'b0;

    // Observation bookkeeping, owned by the compare process.
    bit last_wv = 1'b0;
    int last_acc_idx = -1, stall_run = 0, stall_total = 0, done_cnt = 0, sim_cnt = 0;
    int f_first_stall = -1, f_stalls = 0, f_pushes = 0, fp_row = 0, fp_col = 0, win_n = 0;
    int win_log_r[8], win_log_c[8];

    initial forever begin : model_step
        int r, c;
        bit prod, acc, dec, drained;
        @(posedge clk);
        if (!rst_n) begin
            m_phase = 0; m_n = 0; m_cred = CREDITS; m_err = 1'b0;
            m_wv = 1'b0; m_wr = 0; m_wc = 0;
        end else begin
            r = m_n / IMG_W;
            c = m_n % IMG_W;
            prod = (r >= K - 1) && (c >= K - 1);
            acc = (m_phase == 1) && in_valid && !(prod && m_cred == 0);
            dec = acc && prod;
            drained = (m_phase == 2) && (m_cred == CREDITS);
            m_wv = dec;
            if (dec) begin
                m_wr = r - (K - 1);
                m_wc = c - (K - 1);
            end
            if (out_fire && !dec && m_cred == CREDITS) m_err = 1'b1;
            else m_cred = m_cred + int'(out_fire) - int'(dec);
            case (m_phase)
                0: if (start) begin m_phase = 1; m_n = 0; end
                1: if (acc) begin
                       m_n++;
                       if (m_n == IMG_W * IMG_H) begin m_phase = 2; m_n = 0; end
                   end
                default: if (drained) m_phase = 0;
            endcase
        end
    end

    initial forever begin : compare
        int r, c;
        bit prod, exp_ready, exp_push, exp_done, stall;
        @(negedge clk);
        r = m_n / IMG_W;
        c = m_n % IMG_W;
        prod = (r >= K - 1) && (c >= K - 1);
        exp_ready = (m_phase == 1) && !(prod && m_cred == 0);
        exp_push = exp_ready && in_valid;
        exp_done = (m_phase == 2) && (m_cred == CREDITS);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("lb_push", 32'(lb_push), 32'(exp_push));
        if (exp_push) begin
            check("lb_row", 32'(lb_row), r);
            check("lb_col", 32'(lb_col), c);
        end
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("frame_done", 32'(frame_done), 32'(exp_done));
        check("win_valid", 32'(win_valid), 32'(m_wv));
        if (m_wv) begin
            check("win_row", 32'(win_row), m_wr);
            check("win_col", 32'(win_col), m_wc);
        end
        check("err", 32'(err), 32'(m_err));

        if (m_phase == 0) begin
            f_first_stall = -1; f_stalls = 0; f_pushes = 0; win_n = 0;
        end
        stall = (m_phase == 1) && in_valid && !exp_ready;
        if (stall) begin
            stall_total++; f_stalls++; stall_run++;
            if (f_first_stall < 0) f_first_stall = m_n;
        end else begin
            stall_run = 0;
        end
        if (exp_push && out_fire && prod && m_cred == 1) sim_cnt++;
        if (lb_push === 1'b1) begin
            if (f_pushes == 0) begin fp_row = int'(lb_row); fp_col = int'(lb_col); end
            f_pushes++;
        end
        if (win_valid === 1'b1 && win_n < 8) begin
            win_log_r[win_n] = int'(win_row);
            win_log_c[win_n] = int'(win_col);
            win_n++;
        end
        last_wv = m_wv;
        last_acc_idx = exp_push ? m_n : -1;
        if (exp_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: return a credit one cycle after each window; mode 1: return one only
    // after three stalled cycles, and drain the rest once all pixels are in.
    task automatic run_frame(input int mode, input int gap_idx, input int abort_idx, output bit done_ok);
        int d0;
        d0 = done_cnt;
        done_ok = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (abort_idx >= 0 && m_phase == 1 && m_n == abort_idx) begin
                rst_n = 1'b0; in_valid = 1'b1; out_fire = 1'b0;
                tick();
                rst_n = 1'b1; in_valid = 1'b0;
                return;
            end
            in_valid = (m_phase == 1) && !(gap_idx >= 0 && last_acc_idx == gap_idx);
            if (mode == 0) out_fire = last_wv;
            else           out_fire = (stall_run == 3) || (m_phase == 2 && m_cred < CREDITS);
            tick();
            if (done_cnt != d0) begin
                done_ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        out_fire = 1'b0;
    endtask

    int exp_wr[4] = '{0, 0, 1, 1};
    int exp_wc[4] = '{0, 1, 0, 1};

    initial begin : main
        bit ok;
        int s0, d0;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_fire = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_lb_push", 32'(lb_push), 0);
        check("rst_win_valid", 32'(win_valid), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_err", 32'(err), 0);

        // Full frame, credits returned one cycle after each window.
        run_frame(0, -1, -1, ok);
        check("s1_frame_done", 32'(ok), 1);
        check("s1_stalls", f_stalls, 0);
        check("s1_first_push_row", fp_row, 0);
        check("s1_first_push_col", fp_col, 0);
        check("s1_win_count", win_n, 4);
        for (int i = 0; i < 4; i++) begin
            check("s1_win_row", win_log_r[i], exp_wr[i]);
            check("s1_win_col", win_log_c[i], exp_wc[i]);
        end

        // Bubble after pixel (2,2): next window-producing accept meets a credit return.
        s0 = sim_cnt;
        run_frame(0, 10, -1, ok);
        check("s3_frame_done", 32'(ok), 1);
        check("s3_simultaneous", sim_cnt - s0, 1);
        check("s3_stalls", f_stalls, 0);

        // Credit return while idle with a full counter.
        out_fire = 1'b1;
        tick();
        out_fire = 1'b0;
        check("s4_err_set", 32'(err), 1);
        repeat (3) tick();
        check("s4_err_sticky", 32'(err), 1);

        // Withheld credits: stall begins at pixel (3,2) = index 14, 4 cycles each at (3,2) and (3,3).
        run_frame(1, -1, -1, ok);
        check("s2_frame_done", 32'(ok), 1);
        check("s2_first_stall_idx", f_first_stall, 14);
        check("s2_stalls", f_stalls, 8);
        check("s2_err_still_set", 32'(err), 1);

        // Reset at pixel (2,1), then a clean frame.
        d0 = done_cnt;
        run_frame(0, -1, 9, ok);
        check("s5_post_rst_busy", 32'(busy), 0);
        check("s5_post_rst_in_ready", 32'(in_ready), 0);
        check("s5_post_rst_err", 32'(err), 0);
        repeat (4) tick();
        check("s5_no_done_from_abort", done_cnt - d0, 0);
        run_frame(0, -1, -1, ok);
        check("s5_frame_done", 32'(ok), 1);
        check("s5_first_push_row", fp_row, 0);
        check("s5_first_push_col", fp_col, 0);
        check("s5_win_count", win_n, 4);

`ifdef CONV2D_WINDOW_CTRL_STATS_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        s0 = stall_total;
        run_frame(1, -1, -1, ok);
        check("st_frame1_done", 32'(ok), 1);
        run_frame(1, -1, -1, ok);
        check("st_frame2_done", 32'(ok), 1);
        check("st_frame_count", frame_count, 2);
        check("st_stall_cycles", stall_cycles, 32'(stall_total - s0));
        check("st_stall_cycles_lit", stall_cycles, 16);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
